// File: rtl/serial_nibble_adder_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_nibble_adder_ctrl
// Purpose  : Performs WIDTH-bit additions one nibble per clock, LSB nibble
//            first, through a single 4-bit ripple-carry slice. A valid/ready
//            handshake is used on both the operand and the result side.
//
// Ports    : clk        rising-edge clock
//            rst        synchronous, active-high reset (aborts any operation)
//            in_valid   operand bundle valid
//            in_ready   controller can accept operands (IDLE only)
//            a, b       WIDTH-bit operands
//            cin        carry-in to nibble 0
//            sub        subtract request (used only with the macro below)
//            out_valid  result valid, held until out_ready
//            out_ready  consumer accepts result
//            sum        WIDTH-bit result
//            cout       carry out of bit WIDTH-1
//            ovf        signed overflow (carry into MSB XOR carry out of MSB)
//            busy       high while computing or holding a result
//
// Parameters: WIDTH must be a multiple of 4 and at least 8. NIB is derived
//             and must not be overridden.
//
// Optional  : define SERIAL_ADDER_ADDSUB_EN to enable a-b when sub=1
//             (B nibbles inverted, nibble-0 carry-in forced to 1). Without
//             it the sub input is ignored and the block only adds.
//
// Revision  : 1.0 - initial release
// ============================================================================
module serial_nibble_adder_ctrl #(
    parameter int WIDTH = 16,
    parameter int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int c_idx_w = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NIB - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [c_idx_w-1:0] r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_cout;
    logic               r_ovf;

    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_s;
    logic [4:0]         w_c;
    logic               w_ovf_nib;
    logic               w_inv;
    logic               w_cin0;
    logic               w_accept;

    assign w_accept = (r_state == c_st_idle) && r_in_ready && in_valid;

`ifdef SERIAL_ADDER_ADDSUB_EN
    logic r_sub;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_sub <= sub;
        end
    end

    // Two's-complement subtract: a + ~b + 1, so cin is ignored when sub=1.
    assign w_inv  = r_sub;
    assign w_cin0 = sub | cin;
`else
    logic w_unused_sub;

    assign w_unused_sub = sub;
    assign w_inv        = 1'b0;
    assign w_cin0       = cin;
`endif

    // Current nibble of each operand; {idx,2'b00} is the bit offset 4*idx.
    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4] ^ {4{w_inv}};

    // The shared 4-bit ripple-carry slice.
    always_comb begin
        w_c    = 5'b0;
        w_s    = 4'b0;
        w_c[0] = r_carry;
        for (int i = 0; i < 4; i++) begin
            w_s[i]   = w_a_nib[i] ^ w_b_nib[i] ^ w_c[i];
            w_c[i+1] = (w_a_nib[i] & w_b_nib[i]) | (w_c[i] & (w_a_nib[i] ^ w_b_nib[i]));
        end
    end

    // Carry into bit 3 recovered from the sum bit, XORed with carry out.
    assign w_ovf_nib = (w_s[3] ^ w_a_nib[3] ^ w_b_nib[3]) ^ w_c[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= w_cin0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= c_st_run;
                    end else begin
                        // Ready rises one cycle after reset releases.
                        r_in_ready <= 1'b1;
                    end
                end

                c_st_run: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_s;
                    r_carry                    <= w_c[4];
                    if (r_idx == c_last_idx) begin
                        r_cout      <= w_c[4];
                        r_ovf       <= w_ovf_nib;
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= c_st_done;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                c_st_done: begin
                    // in_ready stays low here, so a concurrent in_valid is
                    // only seen once back in IDLE.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_st_idle;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/serial_nibble_adder_ctrl.md
Name: serial_nibble_adder_ctrl

Overview:
- Sequencer that performs WIDTH-bit additions by time-multiplexing one 4-bit ripple_carry_adder slice (ports A, B, C, S, Cout), one nibble per clock, LSB nibble first.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area: a wide add uses one 4-bit adder slice instead of WIDTH/4 slices.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count; not overridden by instantiators.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- sub  input  1  subtract request; used only with ADDSUB_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the top nibble.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset: synchronous on rst. Forces state IDLE. Clears in_ready, out_valid, sum, cout, ovf, busy, nibble index, operand registers and carry register to 0. On the first cycle after rst deasserts, in_ready=1.
- rst high in any state, including mid-RUN, aborts the operation. The partial result is discarded and no out_valid is produced.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, cin (and sub), set idx=0, go to RUN.
  - RUN: drive the adder slice with A=a_reg[4*idx+3:4*idx], B=b_reg nibble, C=carry_reg. Register S into sum[4*idx+3:4*idx] and Cout into carry_reg. Increment idx.
    - On the cycle where idx==NIB-1, also capture cout=Cout and ovf, then go to DONE.
    - idx wraps to 0 on leaving RUN.
  - DONE: out_valid=1. sum, cout and ovf are held stable until the handshake. On out_valid&&out_ready, go to IDLE.
- Latency: operands accepted at edge T; RUN occupies edges T+1..T+NIB; out_valid is high from edge T+NIB onward. That is NIB cycles from acceptance to valid, e.g. 4 for WIDTH=16.
- Throughput: one result per NIB+2 cycles with out_ready held high (accept, NIB RUN cycles, DONE, back to IDLE).
- in_ready=0 in RUN and DONE. in_valid in those states is ignored, and a, b, cin may change freely.
- Simultaneous out_ready and in_valid in DONE: the result handshake completes and the FSM goes to IDLE. The new operands are not accepted until the following cycle, because in_ready=0 in DONE.
- out_valid, once asserted, stays high until out_ready; no result is ever dropped.
- sum register bits for nibbles not yet processed hold their previous values during RUN. Consumers sample sum only while out_valid=1.
- ovf is computed from the top nibble: the carry into bit 3 of the slice (S[3]^A[3]^B[3]) XOR Cout.
- Arithmetic is modulo 2^WIDTH; the result is unsigned sum plus cin. cout is the carry out of bit WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_ADDSUB_EN.
- Defined:
  - sub latched with operands.
  - When sub=1, the B nibbles fed to the slice are inverted, and nibble 0's carry-in is forced to 1, ignoring cin.
  - Result is a-b. cout=1 means no borrow; ovf is the signed subtraction overflow.
- Undefined:
  - sub port is present but ignored; the block only adds.

Test Plan:
- WIDTH=16: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
- Full carry ripple across all nibbles: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0.
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> sum, cout, ovf and out_valid stable, in_ready=0 throughout. Raising out_ready returns the FSM to IDLE next cycle, and in_ready=1.
- rst pulsed at the second RUN cycle of a=0xAAAA, b=0x5555 -> no out_valid; outputs 0 and in_ready=1 after reset. A following add 0x0003+0x0004, cin=1 gives 0x0008.
- Back-to-back: in_valid held high with out_ready=1 for three operand sets -> results in order, spaced 6 cycles apart (NIB+2).
- With SERIAL_ADDER_ADDSUB_EN defined: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
